// File: rtl/alu_digit_serial.sv
// Digit-serial WIDTH-bit ALU (AND/OR/ADD/SLT with A/B invert), DIGIT bits per clock.
// Optional macro ALU_DIGIT_SERIAL_BYPASS_EN: logic ops complete in a single cycle.
module alu_digit_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_ctl,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [3:0]        ctl_q, ctl_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

    int unsigned       base;
    logic [DIGIT-1:0]  a_dig, b_dig, sum_dig, op_dig;
    logic [DIGIT:0]    add_ext;
    logic              c_out, c_msb_in, dig_ovf;
`ifdef ALU_DIGIT_SERIAL_BYPASS_EN
    logic [WIDTH-1:0]  byp_a, byp_b;
`endif

    // Datapath for the digit currently selected by idx_q.
    always_comb begin
        base     = 32'(idx_q) * DIGIT;
        a_dig    = a_q[base +: DIGIT] ^ {DIGIT{ctl_q[3]}};
        b_dig    = b_q[base +: DIGIT] ^ {DIGIT{ctl_q[2]}};
        add_ext  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        sum_dig  = add_ext[DIGIT-1:0];
        c_out    = add_ext[DIGIT];
        // Carry into the top bit of the digit, recovered from its sum bit.
        c_msb_in = sum_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
        dig_ovf  = c_msb_in ^ c_out;
        case (ctl_q[1:0])
            2'b00:   op_dig = a_dig & b_dig;
            2'b01:   op_dig = a_dig | b_dig;
            default: op_dig = sum_dig;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ctl_d    = ctl_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        shadow_d = shadow_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
`ifdef ALU_DIGIT_SERIAL_BYPASS_EN
        byp_a    = src1 ^ {WIDTH{ALU_ctl[3]}};
        byp_b    = src2 ^ {WIDTH{ALU_ctl[2]}};
`endif
        case (state_q)
            StIdle, StDone: begin
`ifdef ALU_DIGIT_SERIAL_BYPASS_EN
                if (start && !ALU_ctl[1]) begin
                    result_d = ALU_ctl[0] ? (byp_a | byp_b) : (byp_a & byp_b);
                    zero_d   = (result_d == '0);
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StDone;
                end else
`endif
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    ctl_d   = ALU_ctl;
                    idx_d   = '0;
                    carry_d = ALU_ctl[2];
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                shadow_d[base +: DIGIT] = op_dig;
                carry_d = c_out;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IdxW'(N - 1)) begin
                    idx_d   = '0;
                    state_d = StDone;
                    if (ctl_q[1:0] == 2'b11) begin
                        result_d = {{(WIDTH-1){1'b0}}, sum_dig[DIGIT-1] ^ dig_ovf};
                        cout_d   = c_out;
                        ovf_d    = 1'b0;
                    end else begin
                        result_d = shadow_d;
                        cout_d   = ctl_q[1] & c_out;
                        ovf_d    = ctl_q[1] & dig_ovf;
                    end
                    zero_d = (result_d == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            ctl_q    <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            shadow_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctl_q    <= ctl_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_alu_digit_serial.sv
// Bench for alu_digit_serial (WIDTH=32, DIGIT=4): directed cases plus random ops vs. an
// arithmetic reference model.
module tb_alu_digit_serial;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DIGIT = 4;
`ifdef ALU_DIGIT_SERIAL_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       ALU_ctl;
    logic [WIDTH-1:0] src1, src2, result;
    logic             zero, cout, overflow, busy, done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_res;
    logic        m_z, m_c, m_v;
    int          m_lat;

    alu_digit_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALU_ctl(ALU_ctl),
        .src1(src1), .src2(src2), .result(result), .zero(zero), .cout(cout),
        .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed overflow from operand/result signs, carry from a 33-bit sum.
    function automatic void model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic c,
                                  output logic v);
        logic [31:0] aa, bb;
        logic [32:0] s;
        logic        ovf;
        aa  = ctl[3] ? ~a : a;
        bb  = ctl[2] ? ~b : b;
        s   = {1'b0, aa} + {1'b0, bb} + 33'(ctl[2]);
        ovf = (aa[31] == bb[31]) && (s[31] != aa[31]);
        case (ctl[1:0])
            2'b00:   begin r = aa & bb; c = 1'b0; v = 1'b0; end
            2'b01:   begin r = aa | bb; c = 1'b0; v = 1'b0; end
            2'b10:   begin r = s[31:0]; c = s[32]; v = ovf; end
            default: begin r = {31'b0, s[31] ^ ovf}; c = s[32]; v = 1'b0; end
        endcase
        z = (r == 32'd0);
    endfunction

    function automatic int lat(input logic [3:0] ctl);
        return (Byp && !ctl[1]) ? 0 : 8;
    endfunction

    // Ends at E0 + #1 with start released and operands scrambled.
    task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALU_ctl = ctl;
        src1    = a;
        src2    = b;
        start   = 1'b1;
        model(ctl, a, b, m_res, m_z, m_c, m_v);
        m_lat = lat(ctl);
        @(posedge clk);
        #1;
        start   = 1'b0;
        src1    = $urandom;
        src2    = $urandom;
        ALU_ctl = 4'($urandom);
    endtask

    task automatic wait_done(input string tag, input int pre);
        int edges = pre;
        int bc    = pre;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) bc++;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".lat"}, 64'(edges), 64'(m_lat));
        check({tag, ".busy"}, 64'(bc), 64'(m_lat));
        check({tag, ".result"}, 64'(result), 64'(m_res));
        check({tag, ".flags"}, 64'({zero, cout, overflow}), 64'({m_z, m_c, m_v}));
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        logic [3:0]  codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        logic [31:0] corners [6] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                                     32'h1, 32'h5};
        int          seen;
        logic [3:0]  c;
        logic [31:0] a, b;

        rst_n = 1'b0; start = 1'b0; ALU_ctl = '0; src1 = '0; src2 = '0;
        #12;
        check("reset", 64'({result, zero, cout, overflow, busy, done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001); wait_done("add_ovf", 0); idle_check("add_ovf");
        issue(4'b0110, 32'h5, 32'h5);                 wait_done("sub_eq", 0);  idle_check("sub_eq");
        issue(4'b0110, 32'h0, 32'h1);                 wait_done("sub_neg", 0); idle_check("sub_neg");
        issue(4'b0111, 32'hFFFF_FFFF, 32'h1);         wait_done("slt_neg", 0); idle_check("slt_neg");
        issue(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000); wait_done("slt_ovf", 0); idle_check("slt_ovf");
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00); wait_done("and", 0);     idle_check("and");
        issue(4'b1100, 32'h0, 32'h0);                 wait_done("nor", 0);     idle_check("nor");

        // start re-pulsed during RUN must not queue a second operation
        issue(4'b0010, 32'h1234_5678, 32'h1111_1111);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("repulse", 4);
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
        check("repulse.single", 64'(seen), 64'd0);

        // back-to-back: second start presented during the DONE cycle
        issue(4'b0010, 32'hDEAD_BEEF, 32'h0101_0101); wait_done("b2b1", 0);
        issue(4'b0110, 32'h0000_0010, 32'h0000_0020); wait_done("b2b2", 0); idle_check("b2b2");

        // reset during RUN digit 3
        issue(4'b0010, 32'hCAFE_0000, 32'h0000_BABE);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midrst.outs", 64'({result, zero, cout, overflow, busy, done}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
        check("midrst.nodone", 64'(seen), 64'd0);
        issue(4'b0010, 32'd2, 32'd3); wait_done("post_rst_add", 0); idle_check("post_rst_add");

        for (int i = 0; i < 24; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)];
            a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            issue(c, a, b);
            wait_done("rand", 0);
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
